// File: rtl/tile_board_ctrl.sv
// Tetris playfield tile store.
// Holds a shadow board and next-piece preview that game logic writes into,
// arbitrates those writes round-robin, sequences a row-by-row board clear, and
// copies the shadow to the displayed board only at the start of vertical blanking.
module tile_board_ctrl #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int TILE_BITS = 8,
  parameter int NEXT_N    = 16,
  parameter int NREQ      = 2,
  parameter int V_ACTIVE  = 480
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [9:0]                            vcnt,
  input  logic [0:NREQ-1]                       req,
  input  logic [0:NREQ*8-1]                     addr,
  input  logic [0:NREQ*TILE_BITS-1]             wdata,
  output logic [0:NREQ-1]                       gnt,
  input  logic                                  next_we,
  input  logic [0:NEXT_N*TILE_BITS-1]           next_wdata,
  input  logic                                  clear_req,
  output logic                                  busy,
  output logic [0:BOARD_W*BOARD_H*TILE_BITS-1]  tiles,
  output logic [0:NEXT_N*TILE_BITS-1]           next_tile,
  output logic                                  swap_pulse
);

  localparam int          CELLS  = BOARD_W * BOARD_H;
  localparam int          PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          ROW_W  = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);
  localparam logic [9:0]  V_EDGE = 10'(V_ACTIVE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                              state_q, state_d;
  logic [ROW_W-1:0]                    row;
  logic [PTR_W-1:0]                    ptr;
  logic [9:0]                          vcnt_q;
  logic                                pending;
  logic [0:CELLS*TILE_BITS-1]          shadow;
  logic [0:NEXT_N*TILE_BITS-1]         shadow_next;

  int                                  gidx;
  int                                  idx;
  logic                                found;
  logic                                grant_ok;
  logic [7:0]                          addr_sel;
  logic [TILE_BITS-1:0]                wdata_sel;
  logic                                vb_edge;
  logic                                do_swap;

  assign busy    = (state_q == CLEAR);
  assign vb_edge = (vcnt == V_EDGE) && (vcnt_q != V_EDGE);
  assign do_swap = (state_q == IDLE) && (vb_edge || pending);

  // Round-robin search starting at ptr; grants only in IDLE and out of reset.
  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    gnt       = '0;
    found     = 1'b0;
    gidx      = 0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant_ok  = found && rst && (state_q == IDLE);
    addr_sel  = addr[gidx*8 +: 8];
    wdata_sel = wdata[gidx*TILE_BITS +: TILE_BITS];
    if (grant_ok) gnt[gidx] = 1'b1;
  end

  // Next-state logic: start a clear from IDLE, return after the last row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (row == LAST_ROW) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register sees start-of-cycle values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath: tile writes, row clear, preview load, arbitration pointer and display swap.
  // NOTE: the whole store is reset, not just control, so the display comes up blank after any reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow      <= '0;
      shadow_next <= '0;
      tiles       <= '0;
      next_tile   <= '0;
      swap_pulse  <= 1'b0;
      pending     <= 1'b0;
      ptr         <= '0;
      row         <= '0;
      vcnt_q      <= '0;
    end else begin
      vcnt_q     <= vcnt;
      swap_pulse <= do_swap;

      if (grant_ok) begin
        ptr <= PTR_W'((gidx + 1) % NREQ);
        if (int'(addr_sel) < CELLS)
          shadow[int'(addr_sel)*TILE_BITS +: TILE_BITS] <= wdata_sel;
      end

      if (state_q == CLEAR) begin
        for (int c = 0; c < BOARD_W; c++)
          shadow[(int'(row)*BOARD_W + c)*TILE_BITS +: TILE_BITS] <= '0;
        row <= row + ROW_W'(1);
      end else begin
        row <= '0;
      end

      if (next_we) shadow_next <= next_wdata;

      // A vblank start seen mid-clear is deferred; repeated edges collapse into one swap.
      if (state_q == CLEAR) begin
        if (vb_edge) pending <= 1'b1;
      end else if (do_swap) begin
        pending <= 1'b0;
      end

      if (do_swap) begin
        tiles     <= shadow;
        next_tile <= shadow_next;
      end
    end
  end

endmodule

// File: tb/tb_tile_board_ctrl.sv
// Directed self-checking bench for tile_board_ctrl.
module tb_tile_board_ctrl;

  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 20;
  localparam int TILE_BITS = 8;
  localparam int NEXT_N    = 16;
  localparam int NREQ      = 2;
  localparam int CELLS     = BOARD_W * BOARD_H;

  localparam logic [127:0] PAT1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] PAT2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  logic                             clk;
  logic                             rst;
  logic [9:0]                       vcnt;
  logic [0:NREQ-1]                  req;
  logic [0:NREQ*8-1]                addr;
  logic [0:NREQ*TILE_BITS-1]        wdata;
  logic [0:NREQ-1]                  gnt;
  logic                             next_we;
  logic [0:NEXT_N*TILE_BITS-1]      next_wdata;
  logic                             clear_req;
  logic                             busy;
  logic [0:CELLS*TILE_BITS-1]       tiles;
  logic [0:NEXT_N*TILE_BITS-1]      next_tile;
  logic                             swap_pulse;

  int checks = 0;
  int errors = 0;

  tile_board_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vcnt       (vcnt),
    .req        (req),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .next_we    (next_we),
    .next_wdata (next_wdata),
    .clear_req  (clear_req),
    .busy       (busy),
    .tiles      (tiles),
    .next_tile  (next_tile),
    .swap_pulse (swap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tile(input int i);
    return tiles[i*TILE_BITS +: TILE_BITS];
  endfunction

  function automatic int board_mism(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < CELLS; i++)
      if (tiles[i*TILE_BITS +: TILE_BITS] !== v) n++;
    return n;
  endfunction

  task automatic do_swap_seq();
    vcnt = 10'd479;
    tick();
    vcnt = 10'd480;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    vcnt       = 10'd100;
    req        = '0;
    addr       = '0;
    wdata      = '0;
    next_we    = 1'b0;
    next_wdata = '0;
    clear_req  = 1'b0;

    // 1: reset held 3 cycles with random inputs
    for (int c = 0; c < 3; c++) begin
      req        = 2'($urandom);
      addr       = 16'($urandom);
      wdata      = 16'($urandom);
      vcnt       = 10'($urandom_range(0, 1023));
      next_we    = 1'($urandom);
      next_wdata = {$urandom, $urandom, $urandom, $urandom};
      clear_req  = 1'($urandom);
      #1;
      check("rst_gnt", 128'(gnt), 128'd0);
      tick();
    end
    check("rst_tiles", 128'(board_mism(8'h00)), 128'd0);
    check("rst_next", next_tile, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_swap", 128'(swap_pulse), 128'd0);
    req = '0; addr = '0; wdata = '0; next_we = 1'b0; next_wdata = '0;
    clear_req = 1'b0; vcnt = 10'd100;
    rst = 1'b1;
    tick();

    // 2: single write, visible only after vblank edge
    req = 2'b10; addr = {8'd5, 8'd0}; wdata = {8'h3C, 8'h00};
    #1;
    check("t2_gnt", 128'(gnt), 128'(2'b10));
    tick();
    req = '0;
    check("t2_pre_swap", 128'(tile(5)), 128'h00);
    do_swap_seq();
    check("t2_tile5", 128'(tile(5)), 128'h3C);
    check("t2_pulse", 128'(swap_pulse), 128'd1);
    tick();
    check("t2_pulse_once", 128'(swap_pulse), 128'd0);
    vcnt = 10'd100;

    // 3: round-robin from reset pointer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 2'b11; addr = {8'd0, 8'd1}; wdata = {8'hA1, 8'hB2};
    #1; check("t3_gnt0", 128'(gnt), 128'(2'b10)); tick();
    check("t3_gnt1", 128'(gnt), 128'(2'b01)); tick();
    check("t3_gnt2", 128'(gnt), 128'(2'b10)); tick();
    check("t3_gnt3", 128'(gnt), 128'(2'b01)); tick();
    req = '0;
    do_swap_seq();
    check("t3_tile0", 128'(tile(0)), 128'hA1);
    check("t3_tile1", 128'(tile(1)), 128'hB2);
    vcnt = 10'd100;

    // 4: fill board, load preview, then clear
    for (int i = 0; i < CELLS; i++) begin
      req = 2'b10; addr = {8'(i), 8'd0}; wdata = {8'hFF, 8'h00};
      tick();
    end
    req = '0;
    next_we = 1'b1; next_wdata = PAT1;
    tick();
    next_we = 1'b0;
    do_swap_seq();
    check("t4_full", 128'(board_mism(8'hFF)), 128'd0);
    check("t4_next", next_tile, PAT1);
    vcnt = 10'd100;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    req = 2'b10; addr = {8'd7, 8'd0}; wdata = {8'h55, 8'h00};
    for (int i = 0; i < BOARD_H; i++) begin
      #1;
      check("t4_busy", 128'(busy), 128'd1);
      check("t4_gnt_clr", 128'(gnt), 128'd0);
      tick();
    end
    req = '0;
    #1;
    check("t4_busy_end", 128'(busy), 128'd0);
    do_swap_seq();
    check("t4_cleared", 128'(board_mism(8'h00)), 128'd0);
    vcnt = 10'd100;

    // 5: vblank edge during clear is deferred to the first idle cycle
    req = 2'b10; addr = {8'd3, 8'd0}; wdata = {8'hFF, 8'h00};
    tick();
    req = '0;
    do_swap_seq();
    check("t5_tile3", 128'(tile(3)), 128'hFF);
    vcnt = 10'd100;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 1; i <= BOARD_H; i++) begin
      if (i == 2) vcnt = 10'd479;
      if (i == 3) vcnt = 10'd480;
      next_we    = (i == 5);
      next_wdata = PAT2;
      #1;
      check("t5_busy", 128'(busy), 128'd1);
      check("t5_no_swap", 128'(swap_pulse), 128'd0);
      tick();
    end
    next_we = 1'b0;
    check("t5_busy_end", 128'(busy), 128'd0);
    check("t5_pulse_early", 128'(swap_pulse), 128'd0);
    check("t5_tile3_held", 128'(tile(3)), 128'hFF);
    tick();
    check("t5_pulse", 128'(swap_pulse), 128'd1);
    check("t5_zero", 128'(board_mism(8'h00)), 128'd0);
    check("t5_next", next_tile, PAT2);
    tick();
    check("t5_pulse_once", 128'(swap_pulse), 128'd0);
    vcnt = 10'd100;

    // 6: out-of-range write, then reset during clear
    req = 2'b01; addr = {8'd0, 8'd200}; wdata = {8'h00, 8'h77};
    #1;
    check("t6_gnt_oor", 128'(gnt), 128'(2'b01));
    tick();
    req = '0;
    do_swap_seq();
    check("t6_oor_nochange", 128'(board_mism(8'h00)), 128'd0);
    vcnt = 10'd100;
    req = 2'b10; addr = {8'd9, 8'd0}; wdata = {8'h42, 8'h00};
    tick();
    req = '0;
    do_swap_seq();
    check("t6_tile9", 128'(tile(9)), 128'h42);
    vcnt = 10'd100;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b0;
    req = 2'b10; addr = {8'd4, 8'd0}; wdata = {8'h99, 8'h00};
    #1;
    check("t6_gnt_rst", 128'(gnt), 128'd0);
    tick();
    check("t6_busy_rst", 128'(busy), 128'd0);
    check("t6_tiles_rst", 128'(board_mism(8'h00)), 128'd0);
    check("t6_next_rst", next_tile, 128'd0);
    check("t6_swap_rst", 128'(swap_pulse), 128'd0);
    rst = 1'b1;
    req = '0;
    tick();
    check("t6_busy_after", 128'(busy), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
